// File: rtl/pulse_env_seq_pkg.sv
// Shared types and constants for the pulse envelope sequencer.
//   state_t     : sequencer FSM states (IDLE, PLAY)
//   env_cmd_t   : fixed-width tail of a queued command, laid out exactly like
//                 {env_word, cfg} so the low bits of a FIFO word cast to it
//   CFG_* / ENV_* offsets describe the field positions in cfg and env_word.
package pulse_env_seq_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  localparam int ENV_ADDR_WIDTH = 12;
  localparam int ENV_LEN_WIDTH  = 12;

  localparam int CFG_DEST_LSB  = 0;
  localparam int CFG_DEST_W    = 2;
  localparam int CFG_MODE_LSB  = 2;
  localparam int CFG_MODE_W    = 2;
  localparam int ENV_ADDR_LSB  = 0;
  localparam int ENV_LEN_LSB   = 12;

  localparam int ENV_CMD_W = ENV_LEN_WIDTH + ENV_ADDR_WIDTH + CFG_MODE_W + CFG_DEST_W;

  typedef struct packed {
    logic [ENV_LEN_WIDTH-1:0]  len;
    logic [ENV_ADDR_WIDTH-1:0] start;
    logic [CFG_MODE_W-1:0]     mode;
    logic [CFG_DEST_W-1:0]     dest;
  } env_cmd_t;

  function automatic env_cmd_t to_env_cmd(input logic [ENV_CMD_W-1:0] w);
    return env_cmd_t'(w);
  endfunction

endpackage

// File: rtl/pulse_cmd_fifo.sv
// Synchronous command FIFO. The head word is read straight out of the
// registered storage, so dout is valid whenever empty=0.
//   clk/rst : clock, async active-high reset
//   flush   : synchronous empty (wins over push/pop)
//   push/din: write request; accepted if not full, or if full and popping
//   pop     : remove head (ignored when empty)
//   dout    : head word
//   empty/full
module pulse_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_rd  = pop & ~empty & ~flush;
  // When full, a same-cycle pop frees the slot being written.
  assign w_wr  = push & (~full | w_rd) & ~flush;
  assign dout  = r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/pulse_env_sequencer.sv
// Pulse envelope sequencer: queues pulse commands and plays each one as a
// stream of envelope-memory addresses with valid/ready handshaking.
//   clk, reset            : clock, async active-high reset
//   phase/freq/amp        : pulse parameters, captured on cstrobe
//   env_word              : [11:0] envelope start address, [23:12] length
//   cfg                   : [1:0] destination, [3:2] mode (mode[1] reserved)
//   cstrobe, pulse_reset  : command strobe, synchronous flush/abort
//   out_ready             : downstream accepts the current sample
//   out_*                 : current sample (held while stalled)
//   fifo_full, busy       : queue status
//   drop_count            : dropped-command count
// Build option: define PULSE_ENV_SEQ_DROP_COUNT_EN to enable the saturating
// drop counter; otherwise drop_count is tied to zero.
import pulse_env_seq_pkg::*;

module pulse_env_sequencer #(
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 4,
  parameter int ENV_WORD_WIDTH = 24,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic [FREQ_WIDTH-1:0]     freq,
  input  logic [AMP_WIDTH-1:0]      amp,
  input  logic [ENV_WORD_WIDTH-1:0] env_word,
  input  logic [CFG_WIDTH-1:0]      cfg,
  input  logic                      cstrobe,
  input  logic                      pulse_reset,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [PHASE_WIDTH-1:0]    out_phase,
  output logic [FREQ_WIDTH-1:0]     out_freq,
  output logic [AMP_WIDTH-1:0]      out_amp,
  output logic [1:0]                out_dest,
  output logic [ENV_ADDR_WIDTH-1:0] out_env_addr,
  output logic                      out_env_en,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      fifo_full,
  output logic                      busy,
  output logic [15:0]               drop_count
);
  localparam int TAIL_W = ENV_WORD_WIDTH + CFG_WIDTH;
  localparam int CMD_W  = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + TAIL_W;

  state_t                    r_state, w_state_nxt;
  logic [PHASE_WIDTH-1:0]    r_phase;
  logic [FREQ_WIDTH-1:0]     r_freq;
  logic [AMP_WIDTH-1:0]      r_amp;
  logic [1:0]                r_dest;
  logic [ENV_ADDR_WIDTH-1:0] r_addr;
  logic [ENV_LEN_WIDTH-1:0]  r_len, r_cnt;
  logic                      r_env_en;

  logic [CMD_W-1:0]          w_head;
  env_cmd_t                  w_head_env;
  logic                      w_empty, w_full, w_push, w_pop, w_load;
  logic                      w_valid, w_hs, w_last_k, w_end;
  logic                      w_unused_mode_hi;

  assign w_push = cstrobe & ~pulse_reset;

  pulse_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (pulse_reset),
    .push  (w_push),
    .din   ({phase, freq, amp, env_word, cfg}),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  assign w_head_env       = to_env_cmd(w_head[TAIL_W-1:0]);
  assign w_unused_mode_hi = w_head_env.mode[1];

  assign w_valid  = (r_state == S_PLAY);
  assign w_hs     = w_valid & out_ready;
  assign w_last_k = (r_cnt == r_len - 1'b1);
  assign w_end    = w_hs & w_last_k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Pop whenever the sequencer is free (idle, or finishing its last sample).
  // A zero-length head is consumed without entering PLAY.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    if (pulse_reset) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head_env.len != '0) begin
              w_load      = 1'b1;
              w_state_nxt = S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (w_end) begin
            w_state_nxt = S_IDLE;
            if (!w_empty) begin
              w_pop = 1'b1;
              if (w_head_env.len != '0) begin
                w_load      = 1'b1;
                w_state_nxt = S_PLAY;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_freq   <= '0;
      r_amp    <= '0;
      r_dest   <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_env_en <= 1'b0;
    end else if (w_load) begin
      r_phase  <= w_head[CMD_W-1 -: PHASE_WIDTH];
      r_freq   <= w_head[TAIL_W+AMP_WIDTH +: FREQ_WIDTH];
      r_amp    <= w_head[TAIL_W +: AMP_WIDTH];
      r_dest   <= w_head_env.dest;
      r_addr   <= w_head_env.start;
      r_len    <= w_head_env.len;
      r_cnt    <= '0;
      r_env_en <= ~w_head_env.mode[0];
    end else if (w_hs && !w_last_k) begin
      r_addr <= r_addr + 1'b1;  // wraps modulo 4096
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign out_valid    = w_valid;
  assign out_phase    = r_phase;
  assign out_freq     = r_freq;
  assign out_amp      = r_amp;
  assign out_dest     = r_dest;
  assign out_env_addr = r_addr;
  assign out_env_en   = r_env_en & w_valid;
  assign out_first    = w_valid & (r_cnt == '0);
  assign out_last     = w_valid & w_last_k;
  assign fifo_full    = w_full;
  assign busy         = ~w_empty | w_valid;

`ifdef PULSE_ENV_SEQ_DROP_COUNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A command is lost only when the queue is full and nothing leaves it.
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pulse_env_sequencer.sv
module tb_pulse_env_sequencer;
  localparam int PW = 17, FW = 9, AW = 16, CW = 4, EW = 24, DEPTH = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic [PW-1:0] phase = '0;
  logic [FW-1:0] freq = '0;
  logic [AW-1:0] amp = '0;
  logic [EW-1:0] env_word = '0;
  logic [CW-1:0] cfg = '0;
  logic          cstrobe = 1'b0, pulse_reset = 1'b0, out_ready = 1'b1;
  logic          out_valid, out_env_en, out_first, out_last, fifo_full, busy;
  logic [PW-1:0] out_phase;
  logic [FW-1:0] out_freq;
  logic [AW-1:0] out_amp;
  logic [1:0]    out_dest;
  logic [11:0]   out_env_addr;
  logic [15:0]   drop_count;

  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  pulse_env_sequencer #(.PHASE_WIDTH(PW), .FREQ_WIDTH(FW), .AMP_WIDTH(AW),
    .CFG_WIDTH(CW), .ENV_WORD_WIDTH(EW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .phase(phase), .freq(freq), .amp(amp),
    .env_word(env_word), .cfg(cfg), .cstrobe(cstrobe), .pulse_reset(pulse_reset),
    .out_ready(out_ready), .out_valid(out_valid), .out_phase(out_phase),
    .out_freq(out_freq), .out_amp(out_amp), .out_dest(out_dest),
    .out_env_addr(out_env_addr), .out_env_en(out_env_en), .out_first(out_first),
    .out_last(out_last), .fifo_full(fifo_full), .busy(busy), .drop_count(drop_count));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of commands + current pulse
  typedef struct {
    logic [PW-1:0] phase; logic [FW-1:0] freq; logic [AW-1:0] amp;
    int start; int len; logic [1:0] mode; logic [1:0] dest;
  } mcmd_t;

  mcmd_t q[$];
  mcmd_t cur;
  int    m_k = 0;
  bit    m_active = 0;
  int    m_drops = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); m_active = 0; m_k = 0; m_drops = 0;
    end else if (pulse_reset) begin
      q.delete(); m_active = 0;
    end else begin
      bit    fin, free;
      mcmd_t nc;
      fin = m_active && out_ready && (m_k == cur.len - 1);
      if (m_active && out_ready && !fin) m_k++;
      free = !m_active || fin;
      if (fin) m_active = 0;
      // A free sequencer takes one command; zero-length ones vanish.
      if (free && q.size() > 0) begin
        nc = q.pop_front();
        if (nc.len != 0) begin cur = nc; m_k = 0; m_active = 1; end
      end
      if (cstrobe) begin
        if (q.size() < DEPTH) begin
          nc.phase = phase; nc.freq = freq; nc.amp = amp;
          nc.start = int'(env_word[11:0]); nc.len = int'(env_word[23:12]);
          nc.dest = cfg[1:0]; nc.mode = cfg[3:2];
          q.push_back(nc);
        end else begin
`ifdef PULSE_ENV_SEQ_DROP_COUNT_EN
          if (m_drops < 65535) m_drops++;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("valid", 32'(out_valid), 32'(m_active));
      check("busy", 32'(busy), 32'(q.size() > 0 || m_active));
      check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      check("drop_count", 32'(drop_count), 32'(m_drops));
      if (m_active) begin
        check("phase", 32'(out_phase), 32'(cur.phase));
        check("freq", 32'(out_freq), 32'(cur.freq));
        check("amp", 32'(out_amp), 32'(cur.amp));
        check("dest", 32'(out_dest), 32'(cur.dest));
        check("env_addr", 32'(out_env_addr), 32'((cur.start + m_k) % 4096));
        check("env_en", 32'(out_env_en), 32'(!cur.mode[0]));
        check("first", 32'(out_first), 32'(m_k == 0));
        check("last", 32'(out_last), 32'(m_k == cur.len - 1));
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic drive_cmd(input logic [11:0] st, input logic [11:0] ln,
                           input logic [1:0] md, input logic [1:0] ds);
    phase = PW'($urandom); freq = FW'($urandom); amp = AW'($urandom);
    env_word = {ln, st}; cfg = {md, ds};
  endtask

  task automatic send(input logic [11:0] st, input logic [11:0] ln,
                      input logic [1:0] md, input logic [1:0] ds);
    drive_cmd(st, ln, md, ds);
    cstrobe = 1'b1;
    @(posedge clk); #1;
    cstrobe = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(posedge clk); #1; n++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [11:0] exp_addr [4];
    int          hs, samples, firsts, lasts, env_hi;
    bit          seen, gap;
    logic [15:0] d0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_flags", 32'({out_first, out_last, out_env_en}), 0);
    check("rst_data", 32'(out_phase) | 32'(out_freq) | 32'(out_amp) |
                      32'(out_dest) | 32'(out_env_addr), 0);
    check("rst_drops", 32'(drop_count), 0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    // single command: latency N+2, addresses, flags
    send(12'h010, 12'd3, 2'b00, 2'd2);
    @(negedge clk); check("lat_n1_valid", 32'(out_valid), 0);
    @(negedge clk); check("lat_n2_valid", 32'(out_valid), 1);
    check("p1_first", 32'(out_first), 1); check("p1_addr0", 32'(out_env_addr), 32'h010);
    check("p1_dest", 32'(out_dest), 2);   check("p1_env_en", 32'(out_env_en), 1);
    @(negedge clk); check("p1_addr1", 32'(out_env_addr), 32'h011);
    check("p1_mid_flags", 32'({out_first, out_last}), 0);
    @(negedge clk); check("p1_addr2", 32'(out_env_addr), 32'h012);
    check("p1_last", 32'(out_last), 1);
    @(negedge clk); check("p1_done", 32'(out_valid), 0);
    wait_idle();

    // address wrap
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    send(12'hFFE, 12'd4, 2'b00, 2'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("wrap_addr", 32'(out_env_addr), 32'(exp_addr[i]));
    end
    wait_idle();

    // two len=2 pulses with out_ready toggling: no bubble between them
    send(12'h100, 12'd2, 2'b00, 2'd0);
    send(12'h200, 12'd2, 2'b00, 2'd3);
    hs = 0; seen = 0; gap = 0;
    for (int c = 0; c < 30 && hs < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; if (out_ready) hs++; end
      else if (seen) gap = 1;
      @(posedge clk); #1; out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    check("b2b_samples", 32'(hs), 4);
    check("b2b_gap", 32'(gap), 0);
    wait_idle();

    // overflow: 6 strobes while stalled -> 5 accepted, one dropped
    d0 = drop_count;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(12'(i * 16), 12'd1, 2'b00, 2'd0);
      cstrobe = 1'b1;
      @(posedge clk); #1;
    end
    cstrobe = 1'b0;
    @(negedge clk);
    check("ovf_full", 32'(fifo_full), 1);
`ifdef PULSE_ENV_SEQ_DROP_COUNT_EN
    check("ovf_drops", 32'(drop_count), 32'(d0) + 1);
`else
    check("ovf_drops", 32'(drop_count), 0);
`endif
    @(posedge clk); #1; out_ready = 1'b1;
    wait_idle();

    // pulse_reset mid-pulse with two queued and a simultaneous strobe
    d0 = drop_count;
    send(12'h300, 12'd8, 2'b00, 2'd0);
    send(12'h400, 12'd2, 2'b00, 2'd1);
    send(12'h500, 12'd2, 2'b00, 2'd2);
    @(posedge clk); #1;
    drive_cmd(12'h600, 12'd2, 2'b00, 2'd3);
    cstrobe = 1'b1; pulse_reset = 1'b1;
    @(posedge clk); #1;
    cstrobe = 1'b0; pulse_reset = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_busy", 32'(busy), 0);
    check("flush_drops", 32'(drop_count), 32'(d0));
    @(posedge clk); #1;

    // zero-length command then one-sample constant-amp command
    send(12'h020, 12'd0, 2'b00, 2'd0);
    send(12'h030, 12'd1, 2'b01, 2'd1);
    samples = 0; firsts = 0; lasts = 0; env_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        samples++; firsts += int'(out_first); lasts += int'(out_last); env_hi += int'(out_env_en);
      end
    end
    check("len0_samples", 32'(samples), 1);
    check("len1_first", 32'(firsts), 1);
    check("len1_last", 32'(lasts), 1);
    check("len1_env_en", 32'(env_hi), 0);
    wait_idle();

    // randomized traffic, checked every cycle by the model
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      logic [11:0] st;
      st = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + 12'($urandom_range(0, 3))) : 12'($urandom);
      drive_cmd(st, 12'($urandom_range(0, 5)), 2'($urandom), 2'($urandom));
      cstrobe     = ($urandom_range(0, 2) == 0);
      pulse_reset = ($urandom_range(0, 59) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cstrobe = 1'b0; pulse_reset = 1'b0; out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
